// File: rtl/button_color_stepper_if.sv
// Signal bundle between a pushbutton input stage and the LED color logic.
// The slave modport is the stepper side; the master modport is the consumer/stimulus side.
interface button_color_stepper_if;
  logic       btn_n;
  logic       pressed;
  logic       step;
  logic       long_press;
  logic [2:0] color_idx;

  modport slave (
    input  btn_n,
    output pressed,
    output step,
    output long_press,
    output color_idx
  );

  modport master (
    output btn_n,
    input  pressed,
    input  step,
    input  long_press,
    input  color_idx
  );
endinterface

// File: rtl/button_color_stepper.sv
// Debounced pushbutton to 6-entry color index stepper; short press steps, long press forces red.
// Define BTN_AUTOREPEAT_EN to step repeatedly every REPEAT_CYCLES while a long press is held.
module button_color_stepper #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned LONG_CYCLES     = 12000000,
  parameter int unsigned REPEAT_CYCLES   = 2000000
) (
  input logic                  clk,
  input logic                  rst_n,
  button_color_stepper_if.slave bus
);

  localparam int unsigned MAX_AB  = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_ALL);

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    LONG,
    RELEASE_DB
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d, cnt_inc;
  logic          sync1, sync2;
  logic          btn_s;
  logic          pressed_d, step_d, long_d;
  logic [2:0]    idx_d;

  // 6 and 7 are folded to 0 so a corrupted index recovers on the next step
  function automatic logic [2:0] next_idx(input logic [2:0] idx);
    return (idx >= 3'd5) ? 3'd0 : idx + 3'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= bus.btn_n;
      sync2 <= sync1;
    end
  end

  assign btn_s   = ~sync2;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.pressed    <= 1'b0;
      bus.step       <= 1'b0;
      bus.long_press <= 1'b0;
      bus.color_idx  <= '0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      bus.pressed    <= pressed_d;
      bus.step       <= step_d;
      bus.long_press <= long_d;
      bus.color_idx  <= idx_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt_inc;
    pressed_d = bus.pressed;
    step_d    = 1'b0;
    long_d    = 1'b0;
    idx_d     = bus.color_idx;

    case (state)
      IDLE: begin
        cnt_d = '0;
        if (btn_s) state_d = PRESS_DB;
      end

      PRESS_DB: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == DB_LAST) begin
          state_d   = HELD;
          cnt_d     = '0;
          pressed_d = 1'b1;
        end
      end

      // Release is tested first so it wins over a coincident long-press threshold
      HELD: begin
        if (!btn_s) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
          step_d  = 1'b1;
          idx_d   = next_idx(bus.color_idx);
        end else if (cnt == LONG_LAST) begin
          state_d = LONG;
          cnt_d   = '0;
          long_d  = 1'b1;
          idx_d   = '0;
        end
      end

      LONG: begin
        if (!btn_s) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          if (cnt == REP_LAST) begin
            cnt_d  = '0;
            step_d = 1'b1;
            idx_d  = next_idx(bus.color_idx);
          end
`else
          cnt_d = cnt;
`endif
        end
      end

      RELEASE_DB: begin
        if (btn_s) begin
          cnt_d = '0;
        end else if (cnt == DB_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          pressed_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_color_stepper.sv
// Directed bench for button_color_stepper with DEBOUNCE=4, LONG=20, REPEAT=6.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_button_color_stepper;

  logic clk;
  logic rst_n;

  button_color_stepper_if bif ();

  button_color_stepper #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .REPEAT_CYCLES  (6)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        btn_n;
    int unsigned cycles;
    logic        exp_pressed;
    int unsigned exp_steps;
    int unsigned exp_longs;
    logic [2:0]  exp_idx;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   steps_seen;
  int   longs_seen;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned LP_STEPS = 2;
  localparam logic [2:0]  LP_IDX   = 3'd2;
  localparam logic [2:0]  BN_IDX   = 3'd3;
  localparam logic [2:0]  LT_IDX   = 3'd4;
`else
  localparam int unsigned LP_STEPS = 0;
  localparam logic [2:0]  LP_IDX   = 3'd0;
  localparam logic [2:0]  BN_IDX   = 3'd1;
  localparam logic [2:0]  LT_IDX   = 3'd2;
`endif

  task automatic add(input logic b, input int unsigned n, input logic p,
                     input int unsigned s, input int unsigned l, input logic [2:0] idx);
    vec_t v;
    v.btn_n = b; v.cycles = n; v.exp_pressed = p;
    v.exp_steps = s; v.exp_longs = l; v.exp_idx = idx;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: rising edge, then sample at the falling edge and tally pulses
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (bif.step)       steps_seen++;
    if (bif.long_press) longs_seen++;
    if (bif.step && bif.long_press) chk("pulse_overlap", 1, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    // btn, cycles, pressed, steps, longs, idx
    add(1'b0, 10, 1'b1, 0, 0, 3'd0);   // clean short press
    add(1'b1, 10, 1'b0, 1, 0, 3'd1);
    add(1'b0,  3, 1'b0, 0, 0, 3'd1);   // glitch
    add(1'b1, 10, 1'b0, 0, 0, 3'd1);
    add(1'b0, 10, 1'b1, 0, 0, 3'd1);   // wrap run
    add(1'b1, 10, 1'b0, 1, 0, 3'd2);
    add(1'b0, 10, 1'b1, 0, 0, 3'd2);
    add(1'b1, 10, 1'b0, 1, 0, 3'd3);
    add(1'b0, 10, 1'b1, 0, 0, 3'd3);
    add(1'b1, 10, 1'b0, 1, 0, 3'd4);
    add(1'b0, 10, 1'b1, 0, 0, 3'd4);
    add(1'b1, 10, 1'b0, 1, 0, 3'd5);
    add(1'b0, 10, 1'b1, 0, 0, 3'd5);
    add(1'b1, 10, 1'b0, 1, 0, 3'd0);
    add(1'b0, 10, 1'b1, 0, 0, 3'd0);   // walk up to 3
    add(1'b1, 10, 1'b0, 1, 0, 3'd1);
    add(1'b0, 10, 1'b1, 0, 0, 3'd1);
    add(1'b1, 10, 1'b0, 1, 0, 3'd2);
    add(1'b0, 10, 1'b1, 0, 0, 3'd2);
    add(1'b1, 10, 1'b0, 1, 0, 3'd3);
    add(1'b0, 40, 1'b1, LP_STEPS, 1, LP_IDX);   // long press from 3
    add(1'b1, 10, 1'b0, 0, 0, LP_IDX);
    add(1'b0, 10, 1'b1, 0, 0, LP_IDX);          // bounce on release
    add(1'b1,  2, 1'b1, 0, 0, LP_IDX);
    add(1'b0,  2, 1'b1, 1, 0, BN_IDX);
    add(1'b1, 10, 1'b0, 0, 0, BN_IDX);

    // Reset with the button held down
    rst_n = 1'b0;
    bif.btn_n = 1'b0;
    steps_seen = 0; longs_seen = 0;
    repeat (3) tick();
    chk("rst_idx",     int'(bif.color_idx),  0);
    chk("rst_pressed", int'(bif.pressed),    0);
    chk("rst_step",    int'(bif.step),       0);
    chk("rst_long",    int'(bif.long_press), 0);
    bif.btn_n = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < vecs.size(); i++) begin
      bif.btn_n = vecs[i].btn_n;
      steps_seen = 0; longs_seen = 0;
      repeat (vecs[i].cycles) tick();
      chk($sformatf("v%0d_pressed", i), int'(bif.pressed),   int'(vecs[i].exp_pressed));
      chk($sformatf("v%0d_steps",   i), steps_seen,          int'(vecs[i].exp_steps));
      chk($sformatf("v%0d_longs",   i), longs_seen,          int'(vecs[i].exp_longs));
      chk($sformatf("v%0d_idx",     i), int'(bif.color_idx), int'(vecs[i].exp_idx));
    end

    // Release-to-step latency: step seen on the 3rd edge after the raw release
    bif.btn_n = 1'b0;
    repeat (10) tick();
    bif.btn_n = 1'b1;
    steps_seen = 0;
    t = 0;
    while (steps_seen == 0 && t < 12) begin
      tick();
      t++;
    end
    chk("release_latency", t, 3);
    chk("latency_idx", int'(bif.color_idx), int'(LT_IDX));
    repeat (10) tick();

    // Reset while HELD: no pulse, outputs cleared, press must debounce again
    bif.btn_n = 1'b0;
    repeat (10) tick();
    chk("pre_rst_pressed", int'(bif.pressed), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_pressed", int'(bif.pressed),   0);
    chk("midrst_idx",     int'(bif.color_idx), 0);
    steps_seen = 0; longs_seen = 0;
    @(negedge clk);
    repeat (2) tick();
    rst_n = 1'b1;
    t = 0;
    while (!bif.pressed && t < 20) begin
      tick();
      t++;
    end
    chk("midrst_pulses", steps_seen + longs_seen, 0);
    chk("redebounce_cycles", t, 7);
    bif.btn_n = 1'b1;
    steps_seen = 0;
    repeat (10) tick();
    chk("post_rst_steps", steps_seen, 1);
    chk("post_rst_idx", int'(bif.color_idx), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
